// File: rtl/rob_issue_unit.sv
// Issue front end for the reorder buffer: hands out in-order sequence numbers, parks each op
// in a variable-latency execution slot and presents finished ops to the ROB insert port out of order.
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef ROB_BITWIDTH
`define ROB_BITWIDTH 8
`endif

module rob_issue_unit #(
   parameter int p_depth    = `ROB_DEPTH,
   parameter int p_ptrwidth = $clog2(p_depth),
   parameter int p_bitwidth = `ROB_BITWIDTH,
   parameter int p_slots    = 4,
   parameter int p_latwidth = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_en,
   output logic                  iss_cpl,
   input  logic [p_bitwidth-1:0] iss_data,
   input  logic [p_latwidth-1:0] iss_lat,
   output logic [p_ptrwidth-1:0] iss_sn,
   output logic                  ins_en,
   input  logic                  ins_cpl,
   output logic [p_ptrwidth-1:0] ins_sn_in,
   output logic [p_bitwidth-1:0] ins_data_in,
   input  logic                  commit_en,
   output logic                  full,
   output logic                  empty
);

   localparam int                p_slotw = (p_slots > 1) ? $clog2(p_slots) : 1;
   localparam logic [p_ptrwidth:0] depth_c = (p_ptrwidth + 1)'(p_depth);

   logic [p_ptrwidth-1:0] next_sn;
   logic [p_ptrwidth:0]   outstanding;
   logic [p_slots-1:0]    slot_valid;
   logic [p_ptrwidth-1:0] slot_sn   [p_slots];
   logic [p_bitwidth-1:0] slot_data [p_slots];
   logic [p_latwidth-1:0] slot_cnt  [p_slots];

   // A presented-but-unaccepted slot stays selected until the ROB takes it.
   logic                  sel_hold;
   logic [p_slotw-1:0]    sel_idx;

   logic                  free_any;
   logic [p_slotw-1:0]    free_idx;
   logic                  rdy_any;
   logic [p_slotw-1:0]    rdy_idx;
   logic [p_slotw-1:0]    cur_idx;
   logic                  commit_dec;

   // Descending scan so the lowest index wins both priority searches.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      rdy_any  = 1'b0;
      rdy_idx  = '0;
      for (int i = p_slots - 1; i >= 0; i--) begin
         if (!slot_valid[i]) begin
            free_any = 1'b1;
            free_idx = p_slotw'(i);
         end
         if (slot_valid[i] && (slot_cnt[i] == '0)) begin
            rdy_any = 1'b1;
            rdy_idx = p_slotw'(i);
         end
      end
   end

   assign cur_idx     = sel_hold ? sel_idx : rdy_idx;
   assign ins_en      = ~rst & (sel_hold | rdy_any);
   assign ins_sn_in   = ins_en ? slot_sn[cur_idx] : '0;
   assign ins_data_in = ins_en ? slot_data[cur_idx] : '0;

   assign iss_cpl     = iss_en & ~rst & (outstanding < depth_c) & free_any;
   assign iss_sn      = iss_cpl ? next_sn : '0;

   assign full        = ~rst & (outstanding == depth_c);
   assign empty       = rst | (outstanding == '0);
   assign commit_dec  = commit_en & (outstanding != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         next_sn     <= '0;
         outstanding <= '0;
         slot_valid  <= '0;
         sel_hold    <= 1'b0;
         sel_idx     <= '0;
      end else begin
         if (iss_cpl) next_sn <= next_sn + p_ptrwidth'(1);
         case ({iss_cpl, commit_dec})
            2'b10:   outstanding <= outstanding + (p_ptrwidth + 1)'(1);
            2'b01:   outstanding <= outstanding - (p_ptrwidth + 1)'(1);
            default: outstanding <= outstanding;
         endcase
         sel_hold <= ins_en & ~ins_cpl;
         sel_idx  <= cur_idx;
         // Insert frees a valid slot; issue only ever fills a slot that was already free.
         if (ins_en && ins_cpl) slot_valid[cur_idx] <= 1'b0;
         if (iss_cpl) slot_valid[free_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < p_slots; i++) begin
         if (slot_valid[i] && (slot_cnt[i] != '0)) slot_cnt[i] <= slot_cnt[i] - p_latwidth'(1);
      end
      if (iss_cpl) begin
         slot_sn[free_idx]   <= next_sn;
         slot_data[free_idx] <= iss_data;
         slot_cnt[free_idx]  <= iss_lat;
      end
   end

endmodule

// File: tb/tb_rob_issue_unit.sv
// Directed bench for rob_issue_unit with p_depth=8, 8-bit payload, 4 slots.
module tb_rob_issue_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       iss_en;
   logic       iss_cpl;
   logic [7:0] iss_data;
   logic [3:0] iss_lat;
   logic [2:0] iss_sn;
   logic       ins_en;
   logic       ins_cpl;
   logic [2:0] ins_sn_in;
   logic [7:0] ins_data_in;
   logic       commit_en;
   logic       full;
   logic       empty;

   int n_chk  = 0;
   int n_pass = 0;

   rob_issue_unit #(
      .p_depth(8), .p_ptrwidth(3), .p_bitwidth(8), .p_slots(4), .p_latwidth(4)
   ) dut (
      .clk(clk), .rst(rst), .iss_en(iss_en), .iss_cpl(iss_cpl), .iss_data(iss_data),
      .iss_lat(iss_lat), .iss_sn(iss_sn), .ins_en(ins_en), .ins_cpl(ins_cpl),
      .ins_sn_in(ins_sn_in), .ins_data_in(ins_data_in), .commit_en(commit_en),
      .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; iss_en = 1'b0; commit_en = 1'b0; ins_cpl = 1'b0;
      iss_data = 8'h00; iss_lat = 4'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; iss_en = 1'b1; iss_data = 8'h55; iss_lat = 4'd0; ins_cpl = 1'b1; commit_en = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_chk++; if (iss_cpl !== 1'b0) $display("FAIL reset_iss_cpl c%0d got=%b exp=0", c, iss_cpl); else n_pass++;
         n_chk++; if (ins_en !== 1'b0) $display("FAIL reset_ins_en c%0d got=%b exp=0", c, ins_en); else n_pass++;
         n_chk++; if (empty !== 1'b1) $display("FAIL reset_empty c%0d got=%b exp=1", c, empty); else n_pass++;
         n_chk++; if (full !== 1'b0) $display("FAIL reset_full c%0d got=%b exp=0", c, full); else n_pass++;
         n_chk++; if (iss_sn !== 3'd0) $display("FAIL reset_iss_sn c%0d got=%0d exp=0", c, iss_sn); else n_pass++;
         n_chk++; if (ins_sn_in !== 3'd0 || ins_data_in !== 8'h00)
            $display("FAIL reset_ins_out c%0d got=%0d/%h exp=0/00", c, ins_sn_in, ins_data_in); else n_pass++;
         tick();
      end
      rst = 1'b0; iss_en = 1'b0;
      #1;
      n_chk++; if (ins_en !== 1'b0 || empty !== 1'b1 || full !== 1'b0)
         $display("FAIL post_reset got ins_en=%b empty=%b full=%b exp 0/1/0", ins_en, empty, full); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      ins_cpl = 1'b1; iss_en = 1'b1; iss_data = 8'hAB; iss_lat = 4'd0;
      #1;
      n_chk++; if (iss_cpl !== 1'b1) $display("FAIL single_iss_cpl got=%b exp=1", iss_cpl); else n_pass++;
      n_chk++; if (iss_sn !== 3'd0) $display("FAIL single_iss_sn got=%0d exp=0", iss_sn); else n_pass++;
      n_chk++; if (ins_en !== 1'b0) $display("FAIL single_ins_en_T got=%b exp=0", ins_en); else n_pass++;
      tick();
      iss_en = 1'b0;
      #1;
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0 || ins_data_in !== 8'hAB)
         $display("FAIL single_insert got en=%b sn=%0d data=%h exp 1/0/ab", ins_en, ins_sn_in, ins_data_in); else n_pass++;
      n_chk++; if (empty !== 1'b0) $display("FAIL single_empty got=%b exp=0", empty); else n_pass++;
      tick();
      #1;
      n_chk++; if (ins_en !== 1'b0 || ins_sn_in !== 3'd0 || ins_data_in !== 8'h00)
         $display("FAIL single_after got en=%b sn=%0d data=%h exp 0/0/00", ins_en, ins_sn_in, ins_data_in); else n_pass++;
   endtask

   task automatic test_out_of_order();
      do_reset();
      ins_cpl = 1'b1; iss_en = 1'b1; iss_data = 8'hA1; iss_lat = 4'd5;
      #1;
      n_chk++; if (iss_cpl !== 1'b1 || iss_sn !== 3'd0)
         $display("FAIL ooo_issue_a got cpl=%b sn=%0d exp 1/0", iss_cpl, iss_sn); else n_pass++;
      tick();
      iss_data = 8'hB2; iss_lat = 4'd0;
      #1;
      n_chk++; if (iss_cpl !== 1'b1 || iss_sn !== 3'd1)
         $display("FAIL ooo_issue_b got cpl=%b sn=%0d exp 1/1", iss_cpl, iss_sn); else n_pass++;
      n_chk++; if (ins_en !== 1'b0) $display("FAIL ooo_T1_ins_en got=%b exp=0", ins_en); else n_pass++;
      tick();
      iss_en = 1'b0;
      #1;
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd1 || ins_data_in !== 8'hB2)
         $display("FAIL ooo_insert_b got en=%b sn=%0d data=%h exp 1/1/b2", ins_en, ins_sn_in, ins_data_in); else n_pass++;
      for (int c = 3; c <= 5; c++) begin
         tick();
         n_chk++; if (ins_en !== 1'b0) $display("FAIL ooo_idle_T%0d got=%b exp=0", c, ins_en); else n_pass++;
      end
      tick();
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0 || ins_data_in !== 8'hA1)
         $display("FAIL ooo_insert_a got en=%b sn=%0d data=%h exp 1/0/a1", ins_en, ins_sn_in, ins_data_in); else n_pass++;
      tick();
      n_chk++; if (ins_en !== 1'b0) $display("FAIL ooo_T7_ins_en got=%b exp=0", ins_en); else n_pass++;
   endtask

   task automatic test_sn_limit();
      do_reset();
      ins_cpl = 1'b1; iss_en = 1'b1; iss_lat = 4'd0;
      for (int i = 0; i < 8; i++) begin
         iss_data = 8'(8'h30 + i);
         #1;
         n_chk++; if (iss_cpl !== 1'b1 || iss_sn !== 3'(i))
            $display("FAIL limit_issue%0d got cpl=%b sn=%0d exp 1/%0d", i, iss_cpl, iss_sn, i); else n_pass++;
         tick();
      end
      commit_en = 1'b1;
      #1;
      n_chk++; if (iss_cpl !== 1'b0) $display("FAIL limit_blocked got=%b exp=0", iss_cpl); else n_pass++;
      n_chk++; if (full !== 1'b1) $display("FAIL limit_full got=%b exp=1", full); else n_pass++;
      tick();
      commit_en = 1'b0;
      #1;
      n_chk++; if (iss_cpl !== 1'b1 || iss_sn !== 3'd0)
         $display("FAIL limit_wrap got cpl=%b sn=%0d exp 1/0", iss_cpl, iss_sn); else n_pass++;
      n_chk++; if (full !== 1'b0) $display("FAIL limit_not_full got=%b exp=0", full); else n_pass++;
      tick();
      iss_en = 1'b0;
      #1;
      n_chk++; if (full !== 1'b1) $display("FAIL limit_refull got=%b exp=1", full); else n_pass++;
   endtask

   task automatic test_slot_exhaust();
      do_reset();
      ins_cpl = 1'b1; iss_en = 1'b1; iss_lat = 4'd15;
      for (int i = 0; i < 4; i++) begin
         iss_data = 8'(8'h10 + i);
         #1;
         n_chk++; if (iss_cpl !== 1'b1) $display("FAIL slots_issue%0d got=%b exp=1", i, iss_cpl); else n_pass++;
         tick();
      end
      iss_data = 8'h14; iss_lat = 4'd0;
      for (int c = 4; c <= 16; c++) begin
         #1;
         n_chk++; if (iss_cpl !== 1'b0) $display("FAIL slots_blocked_T%0d got=%b exp=0", c, iss_cpl); else n_pass++;
         if (c == 16) begin
            n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0 || ins_data_in !== 8'h10)
               $display("FAIL slots_first_insert got en=%b sn=%0d data=%h exp 1/0/10", ins_en, ins_sn_in, ins_data_in); else n_pass++;
         end
         tick();
      end
      #1;
      n_chk++; if (iss_cpl !== 1'b1 || iss_sn !== 3'd4)
         $display("FAIL slots_reissue got cpl=%b sn=%0d exp 1/4", iss_cpl, iss_sn); else n_pass++;
      tick();
      iss_en = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      iss_en = 1'b1; iss_data = 8'hC0; iss_lat = 4'd0;
      tick();
      iss_data = 8'hC1;
      for (int c = 1; c <= 3; c++) begin
         #1;
         n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0 || ins_data_in !== 8'hC0)
            $display("FAIL bp_hold_T%0d got en=%b sn=%0d data=%h exp 1/0/c0", c, ins_en, ins_sn_in, ins_data_in); else n_pass++;
         tick();
         iss_en = 1'b0;
      end
      ins_cpl = 1'b1;
      #1;
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0) $display("FAIL bp_xfer0 got en=%b sn=%0d exp 1/0", ins_en, ins_sn_in); else n_pass++;
      tick();
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd1 || ins_data_in !== 8'hC1)
         $display("FAIL bp_xfer1 got en=%b sn=%0d data=%h exp 1/1/c1", ins_en, ins_sn_in, ins_data_in); else n_pass++;
      tick();
      n_chk++; if (ins_en !== 1'b0) $display("FAIL bp_drained got=%b exp=0", ins_en); else n_pass++;
   endtask

   // Higher slot presents first; a lower slot turning ready must not steal the held selection.
   task automatic test_hold_priority();
      do_reset();
      iss_en = 1'b1; iss_data = 8'hD0; iss_lat = 4'd3;
      tick();
      iss_data = 8'hD1; iss_lat = 4'd0;
      tick();
      iss_en = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         #1;
         n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd1 || ins_data_in !== 8'hD1)
            $display("FAIL hold_T%0d got en=%b sn=%0d data=%h exp 1/1/d1", c, ins_en, ins_sn_in, ins_data_in); else n_pass++;
         tick();
      end
      ins_cpl = 1'b1;
      #1;
      n_chk++; if (ins_sn_in !== 3'd1) $display("FAIL hold_xfer_first got=%0d exp=1", ins_sn_in); else n_pass++;
      tick();
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0 || ins_data_in !== 8'hD0)
         $display("FAIL hold_xfer_second got en=%b sn=%0d data=%h exp 1/0/d0", ins_en, ins_sn_in, ins_data_in); else n_pass++;
      tick();
      n_chk++; if (ins_en !== 1'b0) $display("FAIL hold_drained got=%b exp=0", ins_en); else n_pass++;
   endtask

   task automatic test_commit();
      do_reset();
      commit_en = 1'b1;
      tick();
      commit_en = 1'b0;
      n_chk++; if (empty !== 1'b1) $display("FAIL commit_at_zero got empty=%b exp=1", empty); else n_pass++;
      ins_cpl = 1'b1; iss_en = 1'b1; iss_lat = 4'd0; iss_data = 8'h01;
      tick();
      n_chk++; if (empty !== 1'b0) $display("FAIL commit_one_out got empty=%b exp=0", empty); else n_pass++;
      commit_en = 1'b1; iss_data = 8'h02;
      tick();
      iss_en = 1'b0; commit_en = 1'b0;
      #1;
      n_chk++; if (empty !== 1'b0) $display("FAIL commit_both got empty=%b exp=0", empty); else n_pass++;
      commit_en = 1'b1;
      tick();
      commit_en = 1'b0;
      n_chk++; if (empty !== 1'b1) $display("FAIL commit_drain got empty=%b exp=1", empty); else n_pass++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      iss_en = 1'b1; iss_data = 8'hE0; iss_lat = 4'd0;
      tick();
      iss_data = 8'hE1; iss_lat = 4'd6;
      tick();
      iss_en = 1'b0;
      #1;
      n_chk++; if (ins_en !== 1'b1 || ins_sn_in !== 3'd0) $display("FAIL midrst_pre got en=%b sn=%0d exp 1/0", ins_en, ins_sn_in); else n_pass++;
      rst = 1'b1;
      #1;
      n_chk++; if (ins_en !== 1'b0 || ins_sn_in !== 3'd0 || empty !== 1'b1 || full !== 1'b0)
         $display("FAIL midrst_during got en=%b sn=%0d empty=%b full=%b exp 0/0/1/0", ins_en, ins_sn_in, empty, full); else n_pass++;
      tick();
      rst = 1'b0; ins_cpl = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_chk++; if (ins_en !== 1'b0 || empty !== 1'b1)
            $display("FAIL midrst_after_c%0d got en=%b empty=%b exp 0/1", c, ins_en, empty); else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_out_of_order();
      test_sn_limit();
      test_slot_exhaust();
      test_backpressure();
      test_hold_priority();
      test_commit();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
